maxpool1d_requant: RTL and testbench

// - Downstream of the ReLU stage: consumes the signed WIDTH-bit post-ReLU stream, 1-D max-pools
//   non-overlapping windows of POOL samples, then requantises (round + shift + saturate) to

---
 rtl/maxpool1d_requant.sv | 132 +++++++++++++
 tb/tb_maxpool1d_requant.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/maxpool1d_requant.sv
`default_nettype none
// ============================================================================
// Module   : maxpool1d_requant
// Purpose  : 1-D max pooling over non-overlapping windows of POOL signed
//            samples, followed by round-half-up right shift and unsigned
//            saturation to OUT_WIDTH bits. Valid/ready on both sides, one
//            sample per clock at full throughput.
// Options  : define MAXPOOL_SAT_CNT_EN to add the sat_clr / sat_cnt ports
//            (16-bit saturating count of windows whose result clipped high).
// Revision : 1.0  initial release
// ============================================================================
module maxpool1d_requant #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 8,
  parameter int POOL      = 2,
  parameter int SHIFT     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_valid,
  output logic                    out_last,
`ifdef MAXPOOL_SAT_CNT_EN
  input  logic                    sat_clr,
  output logic [15:0]             sat_cnt,
`endif
  input  logic                    out_ready
);

  localparam int c_CNT_W = $clog2(POOL) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(POOL - 1);
  // Largest representable output, widened to the requant arithmetic width.
  localparam logic signed [WIDTH:0] c_OUT_MAX =
    {{(WIDTH + 1 - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

  logic [c_CNT_W-1:0]      r_cnt;
  logic signed [WIDTH-1:0] r_max;
  logic [OUT_WIDTH-1:0]    r_out_data;
  logic                    r_out_valid;
  logic                    r_out_last;

  logic                    w_accept;
  logic                    w_close;
  logic                    w_fire;
  logic signed [WIDTH-1:0] w_max;
  logic signed [WIDTH:0]   w_ext;
  logic signed [WIDTH:0]   w_r;
  logic                    w_neg;
  logic                    w_over;
  logic [OUT_WIDTH-1:0]    w_q;

  // Ready only depends on the output slot being free or draining this cycle.
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_fire    = r_out_valid && out_ready;
  assign w_close   = w_accept && ((r_cnt == c_LAST) || in_last);

  // Running maximum including the sample being accepted this cycle.
  assign w_max = (r_cnt == '0) ? in_data
                               : ((in_data > r_max) ? in_data : r_max);

  // One extra bit so the rounding offset can never wrap.
  assign w_ext = {w_max[WIDTH-1], w_max};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [WIDTH:0] c_HALF =
        {{WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
      logic signed [WIDTH:0] w_sum;
      assign w_sum = w_ext + c_HALF;
      assign w_r   = w_sum >>> SHIFT;
    end else begin : g_noround
      assign w_r = w_ext;
    end
  endgenerate

  // Clamp negatives to zero and large values to all-ones.
  assign w_neg  = w_r[WIDTH];
  assign w_over = !w_neg && (w_r > c_OUT_MAX);
  assign w_q    = w_neg  ? '0 :
                  w_over ? '1 : w_r[OUT_WIDTH-1:0];

  // Window counter, running max and the single-entry output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_max       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_max <= w_max;
        r_cnt <= w_close ? '0 : r_cnt + c_CNT_W'(1);
      end
      if (w_close) begin
        r_out_data  <= w_q;
        r_out_last  <= in_last;
        r_out_valid <= 1'b1;
      end else if (w_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

`ifdef MAXPOOL_SAT_CNT_EN
  logic [15:0] r_sat_cnt;

  // Saturating count of clipped windows; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (sat_clr) begin
      r_sat_cnt <= '0;
    end else if (w_close && w_over && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign sat_cnt = r_sat_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_maxpool1d_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool1d_requant
// Purpose  : Directed self-checking bench. Instance A uses default parameters
//            (POOL=2, SHIFT=8); instance B uses POOL=4 for partial windows.
// Options  : MAXPOOL_SAT_CNT_EN adds saturation-counter checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_maxpool1d_requant;

  logic clk = 1'b0;
  logic rst;

  logic signed [31:0] a_in_data;
  logic               a_in_valid, a_in_last, a_in_ready;
  logic [7:0]         a_out_data;
  logic               a_out_valid, a_out_last, a_out_ready;

  logic signed [31:0] b_in_data;
  logic               b_in_valid, b_in_last, b_in_ready;
  logic [7:0]         b_out_data;
  logic               b_out_valid, b_out_last, b_out_ready;

`ifdef MAXPOOL_SAT_CNT_EN
  logic        a_sat_clr, b_sat_clr;
  logic [15:0] a_sat_cnt, b_sat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // 100 MHz clock.
  always #5 clk = ~clk;

  maxpool1d_requant u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_last   (a_in_last),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_last  (a_out_last),
`ifdef MAXPOOL_SAT_CNT_EN
    .sat_clr   (a_sat_clr),
    .sat_cnt   (a_sat_cnt),
`endif
    .out_ready (a_out_ready)
  );

  maxpool1d_requant #(.POOL(4)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_last   (b_in_last),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_last  (b_out_last),
`ifdef MAXPOOL_SAT_CNT_EN
    .sat_clr   (b_sat_clr),
    .sat_cnt   (b_sat_cnt),
`endif
    .out_ready (b_out_ready)
  );

  // Advance one clock and settle 1 ns past the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Directed sequence; expected values are hand-computed (x+128)>>8, clipped.
  initial begin
    rst = 1'b1;
    a_in_data = 0; a_in_valid = 1'b0; a_in_last = 1'b0; a_out_ready = 1'b1;
    b_in_data = 0; b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b1;
`ifdef MAXPOOL_SAT_CNT_EN
    a_sat_clr = 1'b0; b_sat_clr = 1'b0;
`endif
    tick();
    tick();
    chk("rst_valid", a_out_valid, 0);
    chk("rst_data",  a_out_data,  0);
    chk("rst_last",  a_out_last,  0);
    chk("rst_ready", a_in_ready,  1);
    chk("rst_b_valid", b_out_valid, 0);
    rst = 1'b0;

    // Basic stream 100,300,50,20 -> 1, 0.
    a_in_valid = 1'b1; a_in_data = 100; tick();
    chk("s1_first_idle", a_out_valid, 0);
    a_in_data = 300; tick();
    chk("s1_w0_valid", a_out_valid, 1);
    chk("s1_w0_data",  a_out_data,  1);
    chk("s1_w0_last",  a_out_last,  0);
    a_in_data = 50; tick();
    chk("s1_gap_valid", a_out_valid, 0);
    a_in_data = 20; tick();
    chk("s1_w1_valid", a_out_valid, 1);
    chk("s1_w1_data",  a_out_data,  0);
    a_in_valid = 1'b0; tick();
    chk("s1_drain", a_out_valid, 0);

    // Rounding edge 65407 -> 255, saturation 65408 -> 255.
    a_in_valid = 1'b1; a_in_data = 65407; tick();
    a_in_data = 10; tick();
    chk("rnd_data", a_out_data, 255);
    a_in_data = 65408; tick();
    a_in_data = 0; tick();
    chk("sat_valid", a_out_valid, 1);
    chk("sat_data",  a_out_data,  255);
`ifdef MAXPOOL_SAT_CNT_EN
    chk("sat_cnt_inc", a_sat_cnt, 1);
    a_in_valid = 1'b0; a_sat_clr = 1'b1; tick();
    chk("sat_cnt_clr", a_sat_cnt, 0);
    a_sat_clr = 1'b0;
`endif

    // Negative clamps to 0; consecutive in_last windows fire and close together.
    a_in_valid = 1'b1; a_in_last = 1'b1; a_in_data = -500; tick();
    chk("neg_data", a_out_data, 0);
    chk("neg_last", a_out_last, 1);
    a_in_data = 768; tick();
    chk("ff_valid1", a_out_valid, 1);
    chk("ff_data1",  a_out_data,  3);
    a_in_data = 512; tick();
    chk("ff_valid2", a_out_valid, 1);
    chk("ff_data2",  a_out_data,  2);
    a_in_valid = 1'b0; a_in_last = 1'b0; tick();
    chk("ff_drain", a_out_valid, 0);

    // Backpressure: stall 5 cycles after the first result.
    a_in_valid = 1'b1; a_in_data = 100; tick();
    a_in_data = 300; tick();
    chk("bp_first", a_out_data, 1);
    a_out_ready = 1'b0; a_in_data = 50;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", a_out_valid, 1);
      chk("bp_hold_data",  a_out_data,  1);
      chk("bp_in_ready",   a_in_ready,  0);
    end
    a_out_ready = 1'b1; tick();
    chk("bp_release", a_out_valid, 0);
    a_in_data = 20; tick();
    chk("bp_w1_valid", a_out_valid, 1);
    chk("bp_w1_data",  a_out_data,  0);
    a_in_valid = 1'b0; tick();

    // Reset mid-window discards the half-filled window.
    a_in_valid = 1'b1; a_in_data = 1000; tick();
    a_in_valid = 1'b0; rst = 1'b1; tick();
    chk("rmw_valid", a_out_valid, 0);
    rst = 1'b0; a_in_valid = 1'b1; a_in_data = 768; tick();
    chk("rmw_no_early", a_out_valid, 0);
    a_in_data = 256; tick();
    chk("rmw_valid2", a_out_valid, 1);
    chk("rmw_data",   a_out_data,  3);
    a_in_valid = 1'b0; tick();

    // Reset while the output is stalled drops the pending result.
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 300; tick();
    tick();
    chk("rst_stall_pend", a_out_valid, 1);
    a_in_valid = 1'b0; rst = 1'b1; tick();
    chk("rst_stall_valid", a_out_valid, 0);
    chk("rst_stall_data",  a_out_data,  0);
    chk("rst_stall_ready", a_in_ready,  1);
    rst = 1'b0; a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_data = 768; tick();
    a_in_data = 256; tick();
    chk("rst_stall_after", a_out_data, 3);
    a_in_valid = 1'b0; tick();

    // POOL=4: partial window closed by in_last, then a clean full window.
    b_in_valid = 1'b1; b_in_data = 512; tick();
    chk("p4_idle1", b_out_valid, 0);
    b_in_data = 1024; tick();
    chk("p4_idle2", b_out_valid, 0);
    b_in_data = 768; b_in_last = 1'b1; tick();
    chk("p4_part_valid", b_out_valid, 1);
    chk("p4_part_data",  b_out_data,  4);
    chk("p4_part_last",  b_out_last,  1);
    b_in_data = 256; b_in_last = 1'b0; tick();
    chk("p4_idle3", b_out_valid, 0);
    tick();
    tick();
    chk("p4_idle4", b_out_valid, 0);
    tick();
    chk("p4_full_valid", b_out_valid, 1);
    chk("p4_full_data",  b_out_data,  1);
    chk("p4_full_last",  b_out_last,  0);
    b_in_valid = 1'b0; tick();
    chk("p4_drain", b_out_valid, 0);
`ifdef MAXPOOL_SAT_CNT_EN
    chk("p4_sat_cnt", b_sat_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
